// File: rtl/ram_host_port.sv
// ram_host_port
//   Byte-stream command engine that owns the embedded synchronous RAM port
//   while a serial host loads or dumps memory. A command byte is followed by a
//   4-byte header (addr_hi, addr_lo, len_hi, len_lo).
//   CMD_WR: the next len payload bytes are written to consecutive addresses.
//   CMD_RD: len bytes are read and streamed out on the tx side.
//   Addresses at or above MEM_DEPTH are rejected with a one-cycle err pulse.
//   An increment from MEM_DEPTH-1 wraps the address to 0.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   rx_data/valid/ready incoming command/header/payload bytes
//   tx_data/valid/ready outgoing read bytes (held stable until accepted)
//   mem_we/addr/din     registered RAM request
//   mem_dout            RAM read data, valid one cycle after the address
//   busy                high whenever a command is in progress
//   err                 one-cycle pulse on a rejected header
module ram_host_port #(
  parameter int          ADDR_W    = 15,
  parameter int          MEM_DEPTH = 28672,
  parameter logic [7:0]  CMD_WR    = 8'h57,
  parameter logic [7:0]  CMD_RD    = 8'h52
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  state_t            state, state_next;
  logic              cmd_rd;
  logic [1:0]        hdr_cnt;
  logic [7:0]        addr_hi;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [15:0]       len;

  logic rx_fire;
  logic tx_fire;
  logic is_cmd;
  logic addr_bad;
  logic len_zero;

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;
  assign is_cmd   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  // addr holds the complete header address by the time the 4th byte arrives.
  assign addr_bad = (addr > LAST_ADDR);
  assign len_zero = ({len[15:8], rx_data} == 16'h0000);
  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
  assign busy     = (state != S_IDLE);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and rx_ready
  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    unique case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && is_cmd) state_next = S_HDR;
      end
      S_HDR: begin
        rx_ready = 1'b1;
        if (rx_valid && hdr_cnt == 2'd3) begin
          if (addr_bad || len_zero) state_next = S_IDLE;
          else if (cmd_rd)          state_next = S_RD_ISSUE;
          else                      state_next = S_WDATA;
        end
      end
      S_WDATA: begin
        // Once len reaches 0 this cycle is the final write cycle: stop
        // accepting and return to IDLE after it.
        rx_ready = (len != 16'h0000);
        if (len == 16'h0000) state_next = S_IDLE;
      end
      S_RD_ISSUE: state_next = S_RD_WAIT;
      S_RD_WAIT:  state_next = S_RD_SEND;
      S_RD_SEND: begin
        if (tx_fire) state_next = (len == 16'd1) ? S_IDLE : S_RD_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
    // rx_ready is combinational, so force it low while reset is held to keep
    // every output at 0 during reset.
    if (reset) rx_ready = 1'b0;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_rd   <= 1'b0;
      hdr_cnt  <= 2'd0;
      addr_hi  <= 8'h00;
      addr     <= '0;
      len      <= 16'h0000;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_fire && is_cmd) begin
            cmd_rd  <= (rx_data == CMD_RD);
            hdr_cnt <= 2'd0;
          end
        end
        S_HDR: begin
          if (rx_fire) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            unique case (hdr_cnt)
              2'd0: addr_hi   <= rx_data;
              // Bits above ADDR_W (bit 15 of addr_hi) are dropped here.
              2'd1: addr      <= ADDR_W'({addr_hi, rx_data});
              2'd2: len[15:8] <= rx_data;
              default: begin
                len[7:0] <= rx_data;
                err      <= addr_bad;
                // Pre-load the first read address so RD_ISSUE presents it.
                mem_addr <= addr;
              end
            endcase
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            mem_we   <= 1'b1;
            mem_addr <= addr;
            mem_din  <= rx_data;
            addr     <= addr_inc;
            len      <= len - 16'd1;
          end
        end
        S_RD_WAIT: begin
          tx_data  <= mem_dout;
          tx_valid <= 1'b1;
        end
        S_RD_SEND: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            addr     <= addr_inc;
            len      <= len - 16'd1;
            mem_addr <= addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_host_port.sv
// Directed bench for ram_host_port with a behavioural 1-cycle-latency RAM.
// Inputs are driven 2 ns after posedge; DUT outputs are sampled on negedge.
module tb_ram_host_port;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              busy;
  logic              err;

  ram_host_port dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // RAM model: filled with a[7:0]^C3 on the first edge, then write-or-read.
  logic [7:0] ram [0:32767];
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 8'(i) ^ 8'hC3;
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    int                c;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] txq[$];
  int         txc[$];
  int         err_cnt   = 0;
  int         hold_viol = 0;
  bit         rdmon     = 1'b0;
  bit         rx_seen   = 1'b0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr && (!tx_valid || tx_data !== pd)) hold_viol <= hold_viol + 1;
      pv <= tx_valid;
      pr <= tx_ready;
      pd <= tx_data;
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        txc.push_back(cyc);
      end
      if (mem_we) wlog.push_back('{a: mem_addr, d: mem_din, c: cyc});
      if (err) err_cnt <= err_cnt + 1;
      if (rdmon && rx_ready) rx_seen <= 1'b1;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until it is accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #2;
      if (acc) break;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] a, input logic [15:0] l);
    send_byte(c);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
  endtask

  // Wait (bounded) for the engine to return to IDLE; the final busy value is checked.
  task automatic wait_idle(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete();
    txq.delete();
    txc.delete();
    err_cnt = 0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", rx_ready, 1);
    @(posedge clk);
    #2;

    // 1. Write then read back
    clear_logs();
    send_cmd(8'h57, 16'h0010, 16'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_idle("t1_wr_idle");
    check("t1_wr_count", wlog.size(), 3);
    check("t1_wr0", {wlog[0].a, wlog[0].d}, {15'h0010, 8'hAA});
    check("t1_wr1", {wlog[1].a, wlog[1].d}, {15'h0011, 8'hBB});
    check("t1_wr2", {wlog[2].a, wlog[2].d}, {15'h0012, 8'hCC});
    check("t1_wr_b2b_a", wlog[1].c - wlog[0].c, 1);
    check("t1_wr_b2b_b", wlog[2].c - wlog[1].c, 1);
    clear_logs();
    send_cmd(8'h52, 16'h0010, 16'd3);
    wait_idle("t1_rd_idle");
    check("t1_rd_count", txq.size(), 3);
    check("t1_rd0", txq[0], 8'hAA);
    check("t1_rd1", txq[1], 8'hBB);
    check("t1_rd2", txq[2], 8'hCC);
    check("t1_rd_rate", txc[1] - txc[0], 3);
    check("t1_rd_we", wlog.size(), 0);

    // 2. Wrap at depth
    clear_logs();
    send_cmd(8'h57, 16'h6FFF, 16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_idle("t2_wr_idle");
    check("t2_wr_count", wlog.size(), 2);
    check("t2_wr0", {wlog[0].a, wlog[0].d}, {15'h6FFF, 8'h11});
    check("t2_wr1", {wlog[1].a, wlog[1].d}, {15'h0000, 8'h22});
    clear_logs();
    send_cmd(8'h52, 16'h6FFF, 16'd2);
    wait_idle("t2_rd_idle");
    check("t2_rd_count", txq.size(), 2);
    check("t2_rd0", txq[0], 8'h11);
    check("t2_rd1", txq[1], 8'h22);

    // 3. Invalid address, then a junk byte consumed in IDLE
    clear_logs();
    send_cmd(8'h57, 16'h7000, 16'd1);
    send_byte(8'h55);
    wait_idle("t3_idle");
    check("t3_err_pulses", err_cnt, 1);
    check("t3_no_we", wlog.size(), 0);

    // 4. Backpressure: 5 idle tx_ready cycles before each byte
    clear_logs();
    tx_ready = 1'b0;
    send_cmd(8'h52, 16'h0010, 16'd4);
    rdmon   = 1'b1;
    rx_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (tx_valid) break;
      end
      repeat (5) @(posedge clk);
      #2;
      tx_ready = 1'b1;
      @(posedge clk);
      #2;
      tx_ready = 1'b0;
    end
    rdmon = 1'b0;
    wait_idle("t4_idle");
    tx_ready = 1'b1;
    check("t4_rd_count", txq.size(), 4);
    check("t4_rd0", txq[0], 8'hAA);
    check("t4_rd1", txq[1], 8'hBB);
    check("t4_rd2", txq[2], 8'hCC);
    check("t4_rd3", txq[3], 8'hD0);
    check("t4_hold", hold_viol, 0);
    check("t4_rx_ready_low", rx_seen, 0);

    // 5. Junk bytes and a zero-length read
    clear_logs();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_cmd(8'h52, 16'h0000, 16'd0);
    repeat (6) @(posedge clk);
    #2;
    check("t5_busy", busy, 0);
    check("t5_no_tx", txq.size(), 0);
    check("t5_no_we", wlog.size(), 0);
    check("t5_no_err", err_cnt, 0);

    // 6. Reset after 2 of 4 data bytes have been written
    clear_logs();
    send_cmd(8'h57, 16'h0100, 16'd4);
    send_byte(8'h01);
    send_byte(8'h02);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_rx_ready", rx_ready, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_mem_din", mem_din, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    check("t6_wr_count", wlog.size(), 2);
    check("t6_ram100", ram[15'h0100], 8'h01);
    check("t6_ram101", ram[15'h0101], 8'h02);
    check("t6_ram102", ram[15'h0102], 8'hC1);
    check("t6_ram103", ram[15'h0103], 8'hC0);
    clear_logs();
    send_cmd(8'h52, 16'h0100, 16'd2);
    wait_idle("t6_rd_idle");
    check("t6_rd_count", txq.size(), 2);
    check("t6_rd0", txq[0], 8'h01);
    check("t6_rd1", txq[1], 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
